// File: rtl/ov_fifo_frame_reader.sv
// Reads one H_RES x V_RES frame from an AL422B-style camera FIFO.
// OV_RCLK is driven from a flop and pixels leave on a valid/ready stream.
module ov_fifo_frame_reader #(
  parameter int H_RES         = 320,
  parameter int V_RES         = 240,
  parameter int BYTES_PER_PIX = 2,
  parameter int MSB_FIRST     = 1,
  parameter int RRST_PULSES   = 3
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        ABORT,
  input  logic [7:0]  OV_DATA,
  output logic        OV_RCLK,
  output logic        OV_RRST,
  output logic        OV_OE_N,
  output logic [15:0] PIX_DATA,
  output logic        PIX_VALID,
  input  logic        PIX_READY,
  output logic        PIX_SOF,
  output logic        PIX_EOL,
  output logic        BUSY,
  output logic        DONE
);
  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int RW = $clog2(2*RRST_PULSES+1);
  localparam logic [RW-1:0] R_END  = RW'(2*RRST_PULSES);
  localparam logic [RW-1:0] R_PREV = RW'(2*RRST_PULSES-1);
  localparam logic [XW-1:0] X_END  = XW'(H_RES-1);
  localparam logic [YW-1:0] Y_END  = YW'(V_RES-1);
  localparam logic          B_END  = (BYTES_PER_PIX == 2);

  typedef enum logic [1:0] {IDLE, RRST, READ, FLUSH} state_t;

  state_t          state;
  logic [RW-1:0]   rcnt;
  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            byte_cnt;
  logic            ph1;
  logic [7:0]      byte_hold;
  logic [15:0]     pix_next;
  logic            out_free;
  logic            last_byte;
  logic            last_pix;

  assign out_free  = !PIX_VALID || PIX_READY;
  assign last_byte = (byte_cnt == B_END);
  assign last_pix  = (x == X_END) && (y == Y_END);

  always_comb begin
    pix_next = {8'h00, OV_DATA};
    if (BYTES_PER_PIX == 2) begin
      if (MSB_FIRST != 0) pix_next = {byte_hold, OV_DATA};
      else                pix_next = {OV_DATA, byte_hold};
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      rcnt      <= '0;
      x         <= '0;
      y         <= '0;
      byte_cnt  <= 1'b0;
      ph1       <= 1'b0;
      byte_hold <= 8'h00;
      OV_RCLK   <= 1'b0;
      OV_RRST   <= 1'b1;
      OV_OE_N   <= 1'b1;
      PIX_DATA  <= 16'h0000;
      PIX_VALID <= 1'b0;
      PIX_SOF   <= 1'b0;
      PIX_EOL   <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      if (state != IDLE && ABORT) begin
        state     <= IDLE;
        rcnt      <= '0;
        x         <= '0;
        y         <= '0;
        byte_cnt  <= 1'b0;
        ph1       <= 1'b0;
        OV_RCLK   <= 1'b0;
        OV_RRST   <= 1'b1;
        OV_OE_N   <= 1'b1;
        PIX_VALID <= 1'b0;
        BUSY      <= 1'b0;
      end else begin
        case (state)
          IDLE: if (START && !ABORT) begin
            state   <= RRST;
            BUSY    <= 1'b1;
            OV_OE_N <= 1'b0;
            OV_RRST <= 1'b0;
            OV_RCLK <= 1'b1;
            rcnt    <= '0;
          end
          // rcnt walks high/low pulse halves, then one settle cycle with RRST released
          RRST: begin
            if (rcnt == R_END) begin
              state    <= READ;
              OV_RCLK  <= 1'b1;
              ph1      <= 1'b0;
              byte_cnt <= 1'b0;
            end else begin
              rcnt <= rcnt + 1'b1;
              if (rcnt == R_PREV) begin
                OV_RRST <= 1'b1;
                OV_RCLK <= 1'b0;
              end else begin
                OV_RCLK <= ~OV_RCLK;
              end
            end
          end
          READ: begin
            if (PIX_VALID && PIX_READY) PIX_VALID <= 1'b0;
            if (OV_RCLK) begin
              OV_RCLK <= 1'b0;
              ph1     <= 1'b1;
            end else if (ph1) begin
              if (!last_byte) begin
                byte_hold <= OV_DATA;
                byte_cnt  <= 1'b1;
                ph1       <= 1'b0;
                OV_RCLK   <= 1'b1;
              end else if (out_free) begin
                // The last byte waits in phase 1 (RCLK low) until the output
                // register is free, which also gates the next pixel's first rise.
                PIX_DATA  <= pix_next;
                PIX_SOF   <= (x == '0) && (y == '0);
                PIX_EOL   <= (x == X_END);
                PIX_VALID <= 1'b1;
                ph1       <= 1'b0;
                byte_cnt  <= 1'b0;
                if (last_pix) begin
                  state <= FLUSH;
                  x     <= '0;
                  y     <= '0;
                end else begin
                  OV_RCLK <= 1'b1;
                  if (x == X_END) begin
                    x <= '0;
                    y <= y + 1'b1;
                  end else begin
                    x <= x + 1'b1;
                  end
                end
              end
            end
          end
          FLUSH: if (PIX_VALID && PIX_READY) begin
            PIX_VALID <= 1'b0;
            DONE      <= 1'b1;
            BUSY      <= 1'b0;
            OV_OE_N   <= 1'b1;
            state     <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_ov_fifo_frame_reader.sv
// Bench for ov_fifo_frame_reader: three configurations, a camera FIFO model
// and a frame-level pixel model checked on every handshake.
module tb_ov_fifo_frame_reader;
  logic        CLK = 1'b0;
  logic        RST;
  logic        rdy;
  logic        abort0;
  logic        start [3];
  logic [7:0]  od    [3];
  logic        rclk  [3];
  logic        rrst  [3];
  logic        oen   [3];
  logic        vld   [3];
  logic        sof   [3];
  logic        eol   [3];
  logic        busy  [3];
  logic        done  [3];
  logic [15:0] pd    [3];

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  ov_fifo_frame_reader #(.H_RES(4), .V_RES(2), .BYTES_PER_PIX(2), .MSB_FIRST(1), .RRST_PULSES(3)) u0 (
    .CLK(CLK), .RST(RST), .START(start[0]), .ABORT(abort0), .OV_DATA(od[0]),
    .OV_RCLK(rclk[0]), .OV_RRST(rrst[0]), .OV_OE_N(oen[0]), .PIX_DATA(pd[0]),
    .PIX_VALID(vld[0]), .PIX_READY(rdy), .PIX_SOF(sof[0]), .PIX_EOL(eol[0]),
    .BUSY(busy[0]), .DONE(done[0]));
  ov_fifo_frame_reader #(.H_RES(4), .V_RES(2), .BYTES_PER_PIX(2), .MSB_FIRST(0), .RRST_PULSES(3)) u1 (
    .CLK(CLK), .RST(RST), .START(start[1]), .ABORT(1'b0), .OV_DATA(od[1]),
    .OV_RCLK(rclk[1]), .OV_RRST(rrst[1]), .OV_OE_N(oen[1]), .PIX_DATA(pd[1]),
    .PIX_VALID(vld[1]), .PIX_READY(rdy), .PIX_SOF(sof[1]), .PIX_EOL(eol[1]),
    .BUSY(busy[1]), .DONE(done[1]));
  ov_fifo_frame_reader #(.H_RES(4), .V_RES(1), .BYTES_PER_PIX(1), .MSB_FIRST(1), .RRST_PULSES(3)) u2 (
    .CLK(CLK), .RST(RST), .START(start[2]), .ABORT(1'b0), .OV_DATA(od[2]),
    .OV_RCLK(rclk[2]), .OV_RRST(rrst[2]), .OV_OE_N(oen[2]), .PIX_DATA(pd[2]),
    .PIX_VALID(vld[2]), .PIX_READY(rdy), .PIX_SOF(sof[2]), .PIX_EOL(eol[2]),
    .BUSY(busy[2]), .DONE(done[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Frame model: pixel k is built from frame bytes B*k .. B*k+B-1.
  function automatic logic [15:0] exp_pix(input int i, input int k);
    logic [7:0] b0, b1;
    b0 = 8'((2*k) & 255);
    b1 = 8'((2*k+1) & 255);
    if (i == 2) return {8'h00, 8'(k & 255)};
    if (i == 0) return {b0, b1};
    return {b1, b0};
  endfunction

  int frame_pix [3] = '{8, 8, 4};

  // Camera FIFO: RCLK rise with RRST low rewinds, otherwise presents the next byte.
  int   ptr      [3] = '{0, 0, 0};
  int   rrst_cnt [3] = '{0, 0, 0};
  logic prclk    [3] = '{1'b0, 1'b0, 1'b0};
  initial for (int i = 0; i < 3; i++) od[i] = 8'h00;
  always @(negedge CLK) begin
    for (int i = 0; i < 3; i++) begin
      if (rclk[i] && !prclk[i]) begin
        if (!rrst[i]) begin
          ptr[i] = 0;
          rrst_cnt[i]++;
        end else begin
          od[i] = 8'(ptr[i] & 255);
          ptr[i]++;
        end
      end
      prclk[i] = rclk[i];
    end
  end

  // Stream checker.
  int          k         [3] = '{0, 0, 0};
  int          last_cyc  [3] = '{0, 0, 0};
  logic [15:0] first_pix [3];
  logic [15:0] last_pix  [3];
  logic        pbusy [3] = '{1'b0, 1'b0, 1'b0};
  logic        pvld  [3] = '{1'b0, 1'b0, 1'b0};
  logic [15:0] ppd   [3];
  logic        prdy = 1'b1;
  int          cyc = 0;
  always @(negedge CLK) begin
    cyc++;
    if (!RST) begin
      for (int i = 0; i < 3; i++) begin
        if (busy[i] && !pbusy[i]) k[i] = 0;
        if (vld[i] && pvld[i] && !prdy) chk($sformatf("hold_data%0d", i), pd[i], ppd[i]);
        if (vld[i] && rdy) begin
          chk($sformatf("pix%0d_%0d", i, k[i]), pd[i], exp_pix(i, k[i]));
          chk($sformatf("sof%0d_%0d", i, k[i]), sof[i], k[i] == 0);
          chk($sformatf("eol%0d_%0d", i, k[i]), eol[i], (k[i] % 4) == 3);
          if (i == 2 && k[i] > 0) chk("b1_pixel_gap", cyc - last_cyc[i], 2);
          if (k[i] == 0) first_pix[i] = pd[i];
          last_pix[i] = pd[i];
          last_cyc[i] = cyc;
          k[i]++;
        end
        if (done[i]) chk($sformatf("count%0d", i), k[i], frame_pix[i]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      pbusy[i] = busy[i];
      pvld[i]  = vld[i];
      ppd[i]   = pd[i];
    end
    prdy = rdy;
  end

  task automatic start_frame(input int i);
    @(posedge CLK); #1;
    rrst_cnt[i] = 0;
    start[i] = 1'b1;
    @(posedge CLK); #1;
    start[i] = 1'b0;
    chk("start_rrst_low", rrst[i], 1'b0);
    chk("start_rclk_high", rclk[i], 1'b1);
    chk("start_busy", busy[i], 1'b1);
    chk("start_oe_n", oen[i], 1'b0);
  endtask

  // n counts cycles since the START cycle; exp_n==0 skips the latency check.
  task automatic wait_done(input int i, input int exp_n);
    int n = 1;
    while (!done[i] && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("done_seen", done[i], 1'b1);
    if (exp_n > 0) chk("done_latency", n, exp_n);
    chk("rrst_pulses", rrst_cnt[i], 3);
    chk("done_busy", busy[i], 1'b0);
    chk("done_oe_n", oen[i], 1'b1);
    @(posedge CLK); #1;
    chk("done_pulse_width", done[i], 1'b0);
  endtask

  task automatic wait_pix(input int i, input int kk);
    logic found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      @(posedge CLK); #1;
      if (vld[i] && k[i] == kk) found = 1'b1;
    end
    chk($sformatf("reach_pix%0d", kk), found, 1'b1);
  endtask

  initial begin
    logic seen_done;
    RST = 1'b1; rdy = 1'b1; abort0 = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    #12;
    for (int i = 0; i < 3; i++) begin
      chk("rst_rclk", rclk[i], 1'b0);
      chk("rst_rrst", rrst[i], 1'b1);
      chk("rst_oe_n", oen[i], 1'b1);
      chk("rst_valid", vld[i], 1'b0);
      chk("rst_data", pd[i], 16'h0000);
      chk("rst_sof_eol", {sof[i], eol[i]}, 2'b00);
      chk("rst_busy_done", {busy[i], done[i]}, 2'b00);
    end
    @(posedge CLK); #1;
    RST = 1'b0;

    // RRST 7 + READ 32 + FLUSH 1 cycles elapse, DONE in the cycle after.
    start_frame(0);
    wait_done(0, 41);
    chk("msb_first_pix", first_pix[0], 16'h0001);
    chk("msb_last_pix", last_pix[0], 16'h0E0F);

    start_frame(1);
    wait_done(1, 41);
    chk("lsb_first_pix", first_pix[1], 16'h0100);
    chk("lsb_last_pix", last_pix[1], 16'h0F0E);

    start_frame(2);
    wait_done(2, 17);
    chk("b1_first_pix", first_pix[2], 16'h0000);
    chk("b1_last_pix", last_pix[2], 16'h0003);

    // START together with ABORT in IDLE does nothing.
    @(posedge CLK); #1;
    start[0] = 1'b1; abort0 = 1'b1;
    @(posedge CLK); #1;
    start[0] = 1'b0; abort0 = 1'b0;
    chk("start_abort_busy", busy[0], 1'b0);
    chk("start_abort_rrst", rrst[0], 1'b1);

    // Backpressure while pixel 2 is valid.
    start_frame(0);
    wait_pix(0, 2);
    rdy = 1'b0;
    for (int j = 0; j < 10; j++) begin
      @(negedge CLK);
      chk("stall_data", pd[0], 16'h0405);
      chk("stall_valid", vld[0], 1'b1);
      if (j >= 3) chk("stall_rclk_low", rclk[0], 1'b0);
    end
    @(posedge CLK); #1;
    rdy = 1'b1;
    wait_done(0, 0);
    chk("stall_last_pix", last_pix[0], 16'h0E0F);

    // ABORT during pixel 5.
    start_frame(0);
    wait_pix(0, 5);
    abort0 = 1'b1;
    @(posedge CLK); #1;
    abort0 = 1'b0;
    chk("abort_busy", busy[0], 1'b0);
    chk("abort_valid", vld[0], 1'b0);
    chk("abort_oe_n", oen[0], 1'b1);
    chk("abort_rclk", rclk[0], 1'b0);
    seen_done = done[0];
    repeat (20) begin
      @(negedge CLK);
      seen_done = seen_done | done[0];
    end
    chk("abort_no_done", seen_done, 1'b0);
    start_frame(0);
    wait_done(0, 41);
    chk("restart_first_pix", first_pix[0], 16'h0001);

    // RST during READ phase 0.
    start_frame(0);
    begin
      logic found = 1'b0;
      for (int n = 0; n < 100 && !found; n++) begin
        @(posedge CLK); #1;
        if (busy[0] && rrst[0] && rclk[0]) found = 1'b1;
      end
      chk("reach_read_phase0", found, 1'b1);
    end
    #2 RST = 1'b1;
    #1;
    chk("arst_rclk", rclk[0], 1'b0);
    chk("arst_rrst", rrst[0], 1'b1);
    chk("arst_oe_n", oen[0], 1'b1);
    chk("arst_busy", busy[0], 1'b0);
    start[0] = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    chk("start_in_rst_busy", busy[0], 1'b0);
    chk("start_in_rst_rrst", rrst[0], 1'b1);
    start[0] = 1'b0;
    RST = 1'b0;
    start_frame(0);
    wait_done(0, 41);
    chk("post_rst_first_pix", first_pix[0], 16'h0001);

    repeat (3) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
